alu1_exec_pipe: RTL and testbench

Next-generation ALU1 execute stage for the x86 core. It generalises the fixed 16-bit ALU1 to 8/16/32-bit operand sizes selected per operation, with a parametrised datapath width. Flags are computed at the selected size. Outputs are registered behind a valid/ready pipeline register with flush. The block sits between register-read/memory-read and writeback, and feeds the flag unit and the CMPS/REP logic.

---
 rtl/alu1_pkg.sv | 49 ++++
 rtl/alu1_flag_gen.sv | 42 ++++
 rtl/alu1_exec_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu1_exec_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu1_pkg.sv
// ALU1 execute-stage shared types: operation codes, operand sizes, flag bit positions.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu1_pkg;

    typedef enum logic [3:0] {
        OP_OR    = 4'b0000,
        OP_AND   = 4'b0001,
        OP_SAL   = 4'b0010,
        OP_SAR   = 4'b0011,
        OP_MOV1  = 4'b0100,
        OP_MOV2  = 4'b0101,
        OP_ZERO  = 4'b0110,
        OP_NOT   = 4'b0111,
        OP_INC   = 4'b1000,
        OP_ADD   = 4'b1001,
        OP_STEP  = 4'b1010,
        OP_CMP   = 4'b1011,
        OP_DAA   = 4'b1100,
        OP_RSV_D = 4'b1101,
        OP_RSV_E = 4'b1110,
        OP_RSV_F = 4'b1111
    } alu1_op_e;

    typedef enum logic [1:0] {
        SZ_8   = 2'b00,
        SZ_16  = 2'b01,
        SZ_32  = 2'b10,
        SZ_RSV = 2'b11
    } op_size_e;

    // Bit positions inside every 6-bit flag vector {OF,SF,ZF,AF,PF,CF}.
    localparam int CF = 0;
    localparam int PF = 1;
    localparam int AF = 2;
    localparam int ZF = 3;
    localparam int SF = 4;
    localparam int OF = 5;

    // Operand width in bits; the reserved encoding behaves as 32-bit.
    function automatic int unsigned size_bits(input op_size_e s);
        case (s)
            SZ_8:    return 8;
            SZ_16:   return 16;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/alu1_flag_gen.sv
// Add/subtract flag generator at a selectable operand size N.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module alu1_flag_gen
    import alu1_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,      // first operand, already masked to N bits
    input  logic [DATA_W-1:0] b,      // second operand as added (inverted for subtract), masked
    input  logic [DATA_W:0]   sum,    // a + b + carry-in, one extra bit for the top carry
    input  logic [5:0]        n,      // effective operand size in bits
    input  logic              sub,    // subtract: CF/AF report borrows instead of carries
    output logic [5:0]        flags
);

    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] msbm;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] cout_v;   // cout_v[i] = carry out of bit i
    logic              a_s, b_s, r_s;

    assign mask   = ~({DATA_W{1'b1}} << n);
    assign msbm   = {{(DATA_W-1){1'b0}}, 1'b1} << (n - 6'd1);
    assign res    = sum[DATA_W-1:0] & mask;
    assign cout_v = DATA_W'(({1'b0, a} ^ {1'b0, b} ^ sum) >> 1);
    assign a_s    = |(a & msbm);
    assign b_s    = |(b & msbm);
    assign r_s    = |(res & msbm);

    // Flags at size N; carries become borrows when subtracting.
    always_comb begin
        flags     = '0;
        flags[CF] = (|(cout_v & msbm)) ^ sub;
        flags[AF] = cout_v[3] ^ sub;
        flags[PF] = ~^res[7:0];
        flags[ZF] = (res == '0);
        flags[SF] = r_s;
        flags[OF] = (a_s == b_s) && (r_s != a_s);
    end

endmodule

// File: rtl/alu1_exec_pipe.sv
// ALU1 execute stage, 8/16/32-bit operations; ALU1_SAR_ARITH_EN makes op 0011 arithmetic.
// Latency: 1 cycle through a valid/ready output register; flush drops held and incoming ops.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold while stalled.
module alu1_exec_pipe
    import alu1_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sr1,
    input  logic [DATA_W-1:0] sr2,
    input  logic [DATA_W-1:0] eax,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] mem_out_latched,
    input  logic [3:0]        alu1_op,
    input  logic [1:0]        alu1_op_size,
    input  logic [1:0]        mem_rd_size,
    input  logic              CF_in,
    input  logic              AF_in,
    input  logic              DF_in,
    input  logic              df_val,
    input  logic              ISR,
    input  logic [5:0]        ld_flag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_res1,
    output logic [5:0]        alu1_flags,
    output logic [5:0]        cmps_flags,
    output logic              df_val_ex,
    output logic [5:0]        ld_flag_out
);

    localparam int unsigned DATA_WU = DATA_W;

    // Operand size in bits, clipped to the datapath width.
    function automatic logic [5:0] eff_bits(input logic [1:0] s);
        int unsigned b;
        b = size_bits(op_size_e'(s));
        if (b > DATA_WU) b = DATA_WU;
        return 6'(b);
    endfunction

    // PF/ZF/SF of an already-masked result; all other flags zero.
    function automatic logic [5:0] szp(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] m);
        logic [5:0] f;
        f     = '0;
        f[PF] = ~^r[7:0];
        f[ZF] = (r == '0);
        f[SF] = |(r & m);
        return f;
    endfunction

    alu1_op_e          op;
    logic [5:0]        n, n_c;
    logic [DATA_W-1:0] mask, msbm, cmask;
    logic [DATA_W-1:0] sr1_m;
    logic [4:0]        c;
    logic              xfer;

    assign op    = alu1_op_e'(alu1_op);
    assign n     = eff_bits(alu1_op_size);
    assign n_c   = eff_bits(mem_rd_size);
    assign mask  = ~({DATA_W{1'b1}} << n);
    assign msbm  = {{(DATA_W-1){1'b0}}, 1'b1} << (n - 6'd1);
    assign cmask = ~({DATA_W{1'b1}} << n_c);
    assign sr1_m = sr1 & mask;
    assign c     = sr2[4:0];

    // ---------------- adder path shared by INC / ADD / CMP ----------------
    logic [DATA_W-1:0] fg_a, fg_b, alu_a, alu_b;
    logic              fg_cin, fg_sub;
    logic [DATA_W:0]   alu_sum;
    logic [5:0]        alu_fg_flags;

    // Pick adder operands: INC adds 1, CMP computes eax - sr1 as eax + ~sr1 + 1.
    always_comb begin
        fg_a   = sr1;
        fg_b   = sr2;
        fg_cin = 1'b0;
        fg_sub = 1'b0;
        if (op == OP_INC) begin
            fg_b = {{(DATA_W-1){1'b0}}, 1'b1};
        end else if (op == OP_CMP) begin
            fg_a   = eax;
            fg_b   = ~sr1;
            fg_cin = 1'b1;
            fg_sub = 1'b1;
        end
    end

    assign alu_a   = fg_a & mask;
    assign alu_b   = fg_b & mask;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, fg_cin};

    alu1_flag_gen #(.DATA_W(DATA_W)) u_fg_alu (
        .a     (alu_a),
        .b     (alu_b),
        .sum   (alu_sum),
        .n     (n),
        .sub   (fg_sub),
        .flags (alu_fg_flags)
    );

    // ---------------- CMPS compare: mem_out_latched - mem_out ----------------
    logic [DATA_W-1:0] cm_a, cm_b;
    logic [DATA_W:0]   cm_sum;
    logic [5:0]        cm_flags;

    assign cm_a   = mem_out_latched & cmask;
    assign cm_b   = ~mem_out & cmask;
    assign cm_sum = {1'b0, cm_a} + {1'b0, cm_b} + {{DATA_W{1'b0}}, 1'b1};

    alu1_flag_gen #(.DATA_W(DATA_W)) u_fg_cmps (
        .a     (cm_a),
        .b     (cm_b),
        .sum   (cm_sum),
        .n     (n_c),
        .sub   (1'b1),
        .flags (cm_flags)
    );

    // ---------------- shifts ----------------
    logic [DATA_W:0]     sal_wide;
    logic [DATA_W-1:0]   sal_res;
    logic                sal_cf;
    logic                sar_fill;
    logic [2*DATA_W-1:0] sar_ext;
    logic [DATA_W:0]     sar_sh;   // shifted by c-1: bit 0 is the last bit out

    assign sal_wide = {1'b0, sr1_m} << c;
    assign sal_res  = sal_wide[DATA_W-1:0] & mask;
    assign sal_cf   = |(sal_wide[DATA_W:1] & msbm);

`ifdef ALU1_SAR_ARITH_EN
    assign sar_fill = |(sr1_m & msbm);
`else
    assign sar_fill = 1'b0;
`endif

    assign sar_ext = {{DATA_W{sar_fill}}, sr1_m | (sar_fill ? ~mask : {DATA_W{1'b0}})};
    assign sar_sh  = (DATA_W+1)'(sar_ext >> (c - 5'd1));

    // ---------------- DAA on AL ----------------
    logic       daa_lo, daa_hi;
    logic [7:0] daa_r;

    assign daa_lo = (eax[3:0] > 4'd9) | AF_in;
    assign daa_hi = (eax[7:0] > 8'h99) | CF_in;
    assign daa_r  = eax[7:0] + (daa_lo ? 8'h06 : 8'h00) + (daa_hi ? 8'h60 : 8'h00);

    logic [STEP_W-1:0] step;
    assign step = STEP_W'(n >> 3);

    // ---------------- result / flag selection ----------------
    logic [DATA_W-1:0] res_c;
    logic [5:0]        flg_c, ld_c;

    // Per-op result and flag selection; shift-by-zero and reserved ops suppress flag loads.
    always_comb begin
        res_c = '0;
        flg_c = '0;
        ld_c  = ld_flag_in;
        case (op)
            OP_OR: begin
                res_c = (sr1 | sr2) & mask;
                flg_c = szp(res_c, msbm);
            end
            OP_AND: begin
                res_c = (sr1 & sr2) & mask;
                flg_c = szp(res_c, msbm);
            end
            OP_SAL: begin
                res_c     = sal_res;
                flg_c     = szp(res_c, msbm);
                flg_c[CF] = sal_cf;
                flg_c[OF] = (|(res_c & msbm)) ^ sal_cf;
                if (c == 5'd0) ld_c = '0;
            end
            OP_SAR: begin
                res_c     = (c == 5'd0) ? sr1_m : (sar_sh[DATA_W:1] & mask);
                flg_c     = szp(res_c, msbm);
                flg_c[CF] = (c != 5'd0) & sar_sh[0];
                if (c == 5'd0) ld_c = '0;
            end
            OP_MOV1, OP_MOV2, OP_ZERO, OP_NOT: begin
                case (op)
                    OP_MOV1: res_c = sr1_m;
                    OP_MOV2: res_c = sr2 & mask;
                    OP_NOT:  res_c = ~sr1 & mask;
                    default: res_c = '0;
                endcase
                flg_c = {sr1[11], sr1[7], sr1[6], sr1[4], sr1[2], sr1[0]};
            end
            OP_INC, OP_ADD: begin
                res_c = alu_sum[DATA_W-1:0] & mask;
                flg_c = alu_fg_flags;
            end
            OP_STEP: begin
                res_c = DF_in ? (sr1 - DATA_W'(step)) : (sr1 + DATA_W'(step));
            end
            OP_CMP: begin
                res_c = sr1_m;
                flg_c = alu_fg_flags;
            end
            OP_DAA: begin
                res_c     = {eax[DATA_W-1:8], daa_r};
                flg_c[CF] = daa_hi;
                flg_c[AF] = daa_lo;
                flg_c[PF] = ~^daa_r;
                flg_c[ZF] = (daa_r == 8'h00);
                flg_c[SF] = daa_r[7];
            end
            default: begin
                ld_c = '0;
            end
        endcase
    end

    // ---------------- output register ----------------
    assign in_ready = !out_valid | out_ready;
    assign xfer     = in_valid & in_ready & !flush;

    // Output register: flush empties the stage, payload only moves on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alu_res1    <= '0;
            alu1_flags  <= '0;
            cmps_flags  <= '0;
            df_val_ex   <= 1'b0;
            ld_flag_out <= '0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (xfer)      out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (xfer) begin
                alu_res1    <= res_c;
                alu1_flags  <= flg_c;
                cmps_flags  <= cm_flags;
                df_val_ex   <= ISR ? sr2[10] : df_val;
                ld_flag_out <= ld_c;
            end
        end
    end

endmodule

// File: tb/tb_alu1_exec_pipe.sv
// Self-checking bench for alu1_exec_pipe (DATA_W=32): directed cases, handshake and random stream.
// Latency: results checked one cycle after each transfer.
// Backpressure: exercised with out_ready held low, flush and asynchronous reset.
module tb_alu1_exec_pipe;

`ifdef ALU1_SAR_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] sr1 = '0, sr2 = '0, eax = '0, mem_out = '0, mem_out_latched = '0;
    logic [3:0]  alu1_op = '0;
    logic [1:0]  alu1_op_size = '0, mem_rd_size = '0;
    logic        CF_in = 1'b0, AF_in = 1'b0, DF_in = 1'b0, df_val = 1'b0, ISR = 1'b0;
    logic [5:0]  ld_flag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_res1;
    logic [5:0]  alu1_flags, cmps_flags, ld_flag_out;
    logic        df_val_ex;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu1_exec_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .sr1(sr1), .sr2(sr2), .eax(eax), .mem_out(mem_out), .mem_out_latched(mem_out_latched),
        .alu1_op(alu1_op), .alu1_op_size(alu1_op_size), .mem_rd_size(mem_rd_size),
        .CF_in(CF_in), .AF_in(AF_in), .DF_in(DF_in), .df_val(df_val), .ISR(ISR),
        .ld_flag_in(ld_flag_in), .out_valid(out_valid), .out_ready(out_ready),
        .alu_res1(alu_res1), .alu1_flags(alu1_flags), .cmps_flags(cmps_flags),
        .df_val_ex(df_val_ex), .ld_flag_out(ld_flag_out)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int nbits(input logic [1:0] s);
        if (s == 2'b00) return 8;
        if (s == 2'b01) return 16;
        return 32;
    endfunction

    function automatic longint sx(input longint v, input int n);
        if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic logic par_even(input longint v);
        return ($countones(v & 64'hFF) % 2) == 0;
    endfunction

    function automatic logic [5:0] res_flags(input longint r, input int n, input logic cf, input logic of);
        return {of, ((r >> (n - 1)) & 1) != 0, r == 0, 1'b0, par_even(r), cf};
    endfunction

    function automatic logic [5:0] arith_flags(input longint a, input longint b, input int n, input logic sub);
        longint mask, full, r, sr, lim;
        logic cf, af, of;
        mask = (longint'(1) << n) - 1;
        if (sub) begin
            full = a - b;
            cf = a < b;
            af = (a & 15) < (b & 15);
            sr = sx(a, n) - sx(b, n);
        end else begin
            full = a + b;
            cf = full > mask;
            af = ((a & 15) + (b & 15)) > 15;
            sr = sx(a, n) + sx(b, n);
        end
        r = full & mask;
        lim = longint'(1) << (n - 1);
        of = (sr >= lim) || (sr < -lim);
        return {of, ((r >> (n - 1)) & 1) != 0, r == 0, af, par_even(r), cf};
    endfunction

    function automatic void ref_model(
        input  logic [3:0]  op,
        input  logic [1:0]  sz,
        input  logic [1:0]  msz,
        input  logic [31:0] s1, s2, ea, mo, mol,
        input  logic        cfi, afi, dfi, dfv, isr,
        input  logic [5:0]  ldi,
        output logic [31:0] r,
        output logic [5:0]  fl,
        output logic [5:0]  cm,
        output logic [5:0]  ld,
        output logic        dfo);
        int n, nc, c;
        longint mask, cmask, a, b, res, sa, al, t;
        logic cf, af;
        n = nbits(sz);
        mask = (longint'(1) << n) - 1;
        a = longint'(s1) & mask;
        b = longint'(s2) & mask;
        c = int'(s2 & 32'h1F);
        res = 0;
        fl = '0;
        ld = ldi;
        case (op)
            4'h0: begin res = a | b; fl = res_flags(res, n, 1'b0, 1'b0); end
            4'h1: begin res = a & b; fl = res_flags(res, n, 1'b0, 1'b0); end
            4'h2: begin
                res = (a << c) & mask;
                cf = (c > 0 && c <= n) ? (((a >> (n - c)) & 1) != 0) : 1'b0;
                fl = res_flags(res, n, cf, (((res >> (n - 1)) & 1) != 0) ^ cf);
                if (c == 0) ld = '0;
            end
            4'h3: begin
                sa = ARITH ? sx(a, n) : a;
                res = (sa >>> c) & mask;
                cf = (c > 0) ? (((sa >>> (c - 1)) & 1) != 0) : 1'b0;
                fl = res_flags(res, n, cf, 1'b0);
                if (c == 0) ld = '0;
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
                res = (op == 4'h4) ? a : (op == 4'h5) ? b : (op == 4'h6) ? 0 : (~longint'(s1)) & mask;
                fl = {s1[11], s1[7], s1[6], s1[4], s1[2], s1[0]};
            end
            4'h8: begin res = (a + 1) & mask; fl = arith_flags(a, 1, n, 1'b0); end
            4'h9: begin res = (a + b) & mask; fl = arith_flags(a, b, n, 1'b0); end
            4'hA: begin
                res = (dfi ? longint'(s1) - n / 8 : longint'(s1) + n / 8) & 64'hFFFF_FFFF;
            end
            4'hB: begin res = a; fl = arith_flags(longint'(ea) & mask, a, n, 1'b1); end
            4'hC: begin
                al = longint'(ea) & 255;
                t = al; af = 1'b0; cf = 1'b0;
                if (((al & 15) > 9) || afi) begin t = t + 6; af = 1'b1; end
                if ((al > 'h99) || cfi) begin t = t + 'h60; cf = 1'b1; end
                t = t & 255;
                res = (longint'(ea) & 64'hFFFF_FF00) | t;
                fl = {1'b0, ((t >> 7) & 1) != 0, t == 0, af, par_even(t), cf};
            end
            default: begin res = 0; fl = '0; ld = '0; end
        endcase
        r = 32'(res);
        nc = nbits(msz);
        cmask = (longint'(1) << nc) - 1;
        cm = arith_flags(longint'(mol) & cmask, longint'(mo) & cmask, nc, 1'b1);
        dfo = isr ? s2[10] : dfv;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input logic [3:0] op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b);
        alu1_op = op; alu1_op_size = sz; sr1 = a; sr2 = b; in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (alu_res1 !== 32'h0) begin bad++; $display("FAIL rst_res got=%h want=0", alu_res1); end
        total++; if (alu1_flags !== 6'h0) begin bad++; $display("FAIL rst_flags got=%h want=0", alu1_flags); end
        total++; if (cmps_flags !== 6'h0) begin bad++; $display("FAIL rst_cmps got=%h want=0", cmps_flags); end
        total++; if (df_val_ex !== 1'b0) begin bad++; $display("FAIL rst_df got=%b want=0", df_val_ex); end
        total++; if (ld_flag_out !== 6'h0) begin bad++; $display("FAIL rst_ld got=%h want=0", ld_flag_out); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        out_ready = 1'b1; ld_flag_in = 6'h3F;
        set_op(4'h9, 2'b00, 32'h0000_00FF, 32'h1); tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add8_valid got=%b want=1", out_valid); end
        total++; if (alu_res1 !== 32'h0) begin bad++; $display("FAIL add8_res got=%h want=0", alu_res1); end
        total++; if (alu1_flags !== 6'h0F) begin bad++; $display("FAIL add8_flags got=%h want=0f", alu1_flags); end
        set_op(4'h2, 2'b10, 32'h8000_0001, 32'h1); tick();
        total++; if (alu_res1 !== 32'h2) begin bad++; $display("FAIL sal32_res got=%h want=2", alu_res1); end
        total++; if (alu1_flags !== 6'h21) begin bad++; $display("FAIL sal32_flags got=%h want=21", alu1_flags); end
        total++; if (ld_flag_out !== 6'h3F) begin bad++; $display("FAIL sal32_ld got=%h want=3f", ld_flag_out); end
        set_op(4'h2, 2'b10, 32'h8000_0001, 32'h0); tick();
        total++; if (ld_flag_out !== 6'h0) begin bad++; $display("FAIL sal0_ld got=%h want=0", ld_flag_out); end
        DF_in = 1'b1; set_op(4'hA, 2'b10, 32'h1, 32'h0); tick();
        total++; if (alu_res1 !== 32'hFFFF_FFFD) begin bad++; $display("FAIL step_dn_res got=%h want=fffffffd", alu_res1); end
        total++; if (alu1_flags !== 6'h0) begin bad++; $display("FAIL step_flags got=%h want=0", alu1_flags); end
        DF_in = 1'b0; set_op(4'hA, 2'b00, 32'h1, 32'h0); tick();
        total++; if (alu_res1 !== 32'h2) begin bad++; $display("FAIL step_up_res got=%h want=2", alu_res1); end
        eax = 32'h0000_009A; AF_in = 1'b0; CF_in = 1'b0; set_op(4'hC, 2'b00, 32'h0, 32'h0); tick();
        total++; if (alu_res1 !== 32'h0) begin bad++; $display("FAIL daa_res got=%h want=0", alu_res1); end
        total++; if (alu1_flags !== 6'h0F) begin bad++; $display("FAIL daa_flags got=%h want=0f", alu1_flags); end
        set_op(4'h3, 2'b01, 32'h8000, 32'h4); tick();
        total++; if (alu_res1 !== (ARITH ? 32'hF800 : 32'h0800)) begin bad++; $display("FAIL sar16_res got=%h want=%h", alu_res1, ARITH ? 32'hF800 : 32'h0800); end
        total++; if (alu1_flags[0] !== 1'b0) begin bad++; $display("FAIL sar16_cf got=%b want=0", alu1_flags[0]); end
        mem_out_latched = 32'h10; mem_out = 32'h20; mem_rd_size = 2'b00;
        ISR = 1'b1; df_val = 1'b0; set_op(4'h0, 2'b00, 32'h0, 32'h400); tick();
        total++; if (cmps_flags !== 6'h13) begin bad++; $display("FAIL cmps8_flags got=%h want=13", cmps_flags); end
        total++; if (df_val_ex !== 1'b1) begin bad++; $display("FAIL df_isr got=%b want=1", df_val_ex); end
        ISR = 1'b0; set_op(4'h0, 2'b00, 32'h0, 32'h400); tick();
        total++; if (df_val_ex !== 1'b0) begin bad++; $display("FAIL df_noisr got=%b want=0", df_val_ex); end
        in_valid = 1'b0; tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_handshake();
        out_ready = 1'b0;
        set_op(4'h5, 2'b10, 32'h0, 32'h1111); tick();
        set_op(4'h5, 2'b10, 32'h0, 32'h2222);
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, in_ready); end
            tick();
            total++; if (alu_res1 !== 32'h1111 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%b want=1111/1", i, alu_res1, out_valid); end
        end
        out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        tick();
        total++; if (alu_res1 !== 32'h2222 || out_valid !== 1'b1) begin bad++; $display("FAIL release_res got=%h/%b want=2222/1", alu_res1, out_valid); end
        in_valid = 1'b0; tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_drain got=%b want=0", out_valid); end
        out_ready = 1'b0;
        set_op(4'h5, 2'b10, 32'h0, 32'h3333); tick();
        set_op(4'h5, 2'b10, 32'h0, 32'h4444); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
        total++; if (alu_res1 !== 32'h3333) begin bad++; $display("FAIL flush_blocks got=%h want=3333", alu_res1); end
        out_ready = 1'b1;
        set_op(4'h5, 2'b10, 32'h0, 32'h5555); tick();
        total++; if (alu_res1 !== 32'h5555 || out_valid !== 1'b1) begin bad++; $display("FAIL post_flush got=%h/%b want=5555/1", alu_res1, out_valid); end
        out_ready = 1'b0; ld_flag_in = 6'h3F;
        set_op(4'h5, 2'b10, 32'h0, 32'h6666); tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || alu_res1 !== 32'h0 || ld_flag_out !== 6'h0) begin bad++; $display("FAIL async_rst got=%b/%h/%h want=0/0/0", out_valid, alu_res1, ld_flag_out); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random_stream();
        logic [31:0] er;
        logic [5:0]  ef, ec, el;
        logic        ed;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            alu1_op = 4'($urandom_range(0, 15));
            alu1_op_size = 2'($urandom_range(0, 3));
            mem_rd_size = 2'($urandom_range(0, 3));
            sr1 = $urandom; eax = $urandom; mem_out = $urandom; mem_out_latched = $urandom;
            sr2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 3) == 0) eax = {eax[31:8], 8'($urandom_range(150, 160))};
            {CF_in, AF_in, DF_in, df_val, ISR} = 5'($urandom);
            ld_flag_in = 6'($urandom);
            in_valid = 1'b1;
            ref_model(alu1_op, alu1_op_size, mem_rd_size, sr1, sr2, eax, mem_out, mem_out_latched,
                      CF_in, AF_in, DF_in, df_val, ISR, ld_flag_in, er, ef, ec, el, ed);
            tick();
            total++; if (alu_res1 !== er) begin bad++; $display("FAIL rnd_res[%0d] op=%h sz=%0d got=%h want=%h", i, alu1_op, alu1_op_size, alu_res1, er); end
            total++; if (alu1_flags !== ef) begin bad++; $display("FAIL rnd_flags[%0d] op=%h sz=%0d got=%h want=%h", i, alu1_op, alu1_op_size, alu1_flags, ef); end
            total++; if (cmps_flags !== ec) begin bad++; $display("FAIL rnd_cmps[%0d] sz=%0d got=%h want=%h", i, mem_rd_size, cmps_flags, ec); end
            total++; if (ld_flag_out !== el) begin bad++; $display("FAIL rnd_ld[%0d] op=%h got=%h want=%h", i, alu1_op, ld_flag_out, el); end
            total++; if (df_val_ex !== ed || out_valid !== 1'b1) begin bad++; $display("FAIL rnd_df_valid[%0d] got=%b/%b want=%b/1", i, df_val_ex, out_valid, ed); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
